// File: rtl/mux_scan_serializer_if.sv
// Load port, mux-stage hookup and serial output of the mux scan serializer.
interface mux_scan_serializer_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [7:0] mux_data;
    logic [2:0] sel;
    logic       mux_o;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    // Environment side: load source, external 8:1 mux and serial sink.
    modport master (
        output load_valid,
        output load_data,
        output mux_o,
        input  load_ready,
        input  mux_data,
        input  sel,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  load_valid,
        input  load_data,
        input  mux_o,
        output load_ready,
        output mux_data,
        output sel,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/mux_scan_serializer.sv
// Upstream driver for an 8:1 mux stage: holds a loaded word on the mux data inputs, walks the
// select through all 8 positions and registers the mux output into a framed serial bitstream.
module mux_scan_serializer #(
    parameter int unsigned MSB_FIRST  = 0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    mux_scan_serializer_if.slave        bus
);
    localparam logic [2:0] SelFirst = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] SelLast  = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
    // Adding 3'd7 in 3 bits is a decrement, so one adder covers both directions.
    localparam logic [2:0] SelStep  = (MSB_FIRST != 0) ? 3'd7 : 3'd1;

    localparam logic StIdle  = 1'b0;
    localparam logic StShift = 1'b1;

    logic       state_q,     state_d;
    logic [2:0] sel_q,       sel_d;
    logic [7:0] mux_data_q,  mux_data_d;
    logic       ser_out_q,   ser_out_d;
    logic       ser_valid_q, ser_valid_d;
    logic       ser_last_q,  ser_last_d;

    logic load_ready;
    logic accept;
    logic at_last;

    // Load handshake: ready in IDLE or on the final select position for gapless reload.
    always_comb begin
        at_last    = (sel_q == SelLast);
        load_ready = !rst && ((state_q == StIdle) || ((state_q == StShift) && at_last));
        accept     = bus.load_valid && load_ready;
    end

    // Next-state logic for the IDLE/SHIFT sequencer and the serial output register.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mux_data_d  = mux_data_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;

        if (state_q == StShift) begin
            // The mux output reflects the current select, so it is captured this cycle.
            ser_out_d   = bus.mux_o;
            ser_valid_d = 1'b1;
            ser_last_d  = at_last;
            if (!at_last) begin
                sel_d = sel_q + SelStep;
            end else begin
                sel_d = SelFirst;
                if (accept) begin
                    mux_data_d = bus.load_data;
                end else begin
                    state_d = StIdle;
                end
            end
        end else begin
            ser_out_d   = IDLE_LEVEL;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
            sel_d       = SelFirst;
            if (accept) begin
                mux_data_d = bus.load_data;
                state_d    = StShift;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= SelFirst;
            mux_data_q  <= 8'h00;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mux_data_q  <= mux_data_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    // Drive the interface outputs from registered state.
    always_comb begin
        bus.load_ready = load_ready;
        bus.mux_data   = mux_data_q;
        bus.sel        = sel_q;
        bus.ser_out    = ser_out_q;
        bus.ser_valid  = ser_valid_q;
        bus.ser_last   = ser_last_q;
        bus.busy       = (state_q == StShift);
    end
endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: one LSB-first and one MSB-first instance, each with a
// behavioural 8:1 mux beside it.
module tb_mux_scan_serializer;
    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    mux_scan_serializer_if if0 ();
    mux_scan_serializer_if if1 ();

    // External 8:1 mux stages.
    assign if0.mux_o = if0.mux_data[if0.sel];
    assign if1.mux_o = if1.mux_data[if1.sel];

    mux_scan_serializer #(
        .MSB_FIRST  (0),
        .IDLE_LEVEL (1'b1)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    mux_scan_serializer #(
        .MSB_FIRST  (1),
        .IDLE_LEVEL (1'b1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation mux so the word tasks can target either instance.
    int         cur;
    logic [2:0] o_sel;
    logic       o_ser_out, o_valid, o_last, o_busy, o_ready;
    always_comb begin
        if (cur == 0) begin
            o_sel = if0.sel; o_ser_out = if0.ser_out; o_valid = if0.ser_valid;
            o_last = if0.ser_last; o_busy = if0.busy; o_ready = if0.load_ready;
        end else begin
            o_sel = if1.sel; o_ser_out = if1.ser_out; o_valid = if1.ser_valid;
            o_last = if1.ser_last; o_busy = if1.busy; o_ready = if1.load_ready;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive_load(input bit v, input logic [7:0] d);
        if (cur == 0) begin
            if0.load_valid = v; if0.load_data = d;
        end else begin
            if1.load_valid = v; if1.load_data = d;
        end
    endtask

    // Load one word from IDLE and check select walk, 8 framed bits, then return to idle.
    task automatic run_word(input logic [7:0] data, input logic [0:7] bits, input bit msb);
        logic [2:0] exp_sel;
        @(negedge clk);
        drive_load(1'b1, data);
        check_val("ready_idle", 32'(o_ready), 32'd1);
        @(posedge clk);
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            if (n == 0) begin
                drive_load(1'b0, 8'h00);
                check_val("busy_shift", 32'(o_busy), 32'd1);
            end
            if (n < 8) begin
                exp_sel = msb ? 3'(7 - n) : 3'(n);
                check_val("sel_seq", 32'(o_sel), 32'(exp_sel));
            end
            if (n >= 1 && n <= 8) begin
                check_val("ser_bit", 32'(o_ser_out), 32'(bits[n-1]));
                check_val("ser_valid", 32'(o_valid), 32'd1);
                check_val("ser_last", 32'(o_last), 32'(n == 8));
            end
            if (n == 9) begin
                check_val("idle_valid", 32'(o_valid), 32'd0);
                check_val("idle_level", 32'(o_ser_out), 32'd1);
                check_val("idle_busy", 32'(o_busy), 32'd0);
            end
        end
    endtask

    // Two words with the second load presented from select position start_n; LSB-first only.
    task automatic run_pair(input logic [7:0] w0, input logic [7:0] w1, input int start_n,
                            input logic [0:15] bits);
        @(negedge clk);
        drive_load(1'b1, w0);
        @(posedge clk);
        for (int n = 0; n <= 17; n++) begin
            @(negedge clk);
            if (n == 0) drive_load(1'b0, w1);
            if (n == start_n) drive_load(1'b1, w1);
            if (n == 8) drive_load(1'b0, 8'h00);
            if (n <= 15) begin
                check_val("pair_sel", 32'(o_sel), 32'(n % 8));
                check_val("pair_ready", 32'(o_ready), 32'((n % 8) == 7));
            end
            if (n >= 1 && n <= 16) begin
                check_val("pair_bit", 32'(o_ser_out), 32'(bits[n-1]));
                check_val("pair_valid", 32'(o_valid), 32'd1);
                check_val("pair_last", 32'(o_last), 32'(n == 8 || n == 16));
            end
            if (n == 17) check_val("pair_idle", 32'(o_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cur      = 0;
        if0.load_valid = 1'b0; if0.load_data = 8'h00;
        if1.load_valid = 1'b0; if1.load_data = 8'h00;

        // Reset held two cycles with load_valid asserted.
        rst = 1'b1;
        @(negedge clk);
        if0.load_valid = 1'b1; if0.load_data = 8'hAA;
        if1.load_valid = 1'b1; if1.load_data = 8'hAA;
        @(negedge clk);
        check_val("rst_ready0", 32'(if0.load_ready), 32'd0);
        check_val("rst_ready1", 32'(if1.load_ready), 32'd0);
        @(negedge clk);
        check_val("rst_ready0b", 32'(if0.load_ready), 32'd0);
        rst = 1'b0;
        if0.load_valid = 1'b0;
        if1.load_valid = 1'b0;
        @(negedge clk);
        check_val("rst_ser_out", 32'(if0.ser_out), 32'd1);
        check_val("rst_valid", 32'(if0.ser_valid), 32'd0);
        check_val("rst_sel0", 32'(if0.sel), 32'd0);
        check_val("rst_sel1", 32'(if1.sel), 32'd7);
        check_val("rst_busy", 32'(if0.busy), 32'd0);
        check_val("rst_mux_data", 32'(if0.mux_data), 32'h00);

        // LSB-first single word.
        cur = 0;
        run_word(8'hC8, 8'b0001_0011, 1'b0);

        // MSB-first single word.
        cur = 1;
        run_word(8'hC8, 8'b1100_1000, 1'b1);

        // Back-to-back with load_valid held throughout.
        cur = 0;
        run_pair(8'hC8, 8'h35, 0, 16'b0001_0011_1010_1100);

        // 0xFF presented mid-word is held off until the final select position.
        run_pair(8'hC8, 8'hFF, 3, 16'b0001_0011_1111_1111);

        // Reset after three bits aborts the word.
        @(negedge clk);
        drive_load(1'b1, 8'hC8);
        @(posedge clk);
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            if (n == 0) drive_load(1'b0, 8'h00);
            if (n >= 1) check_val("abort_bit", 32'(o_ser_out), 32'(n == 4));
        end
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_valid", 32'(o_valid), 32'd0);
        check_val("abort_level", 32'(o_ser_out), 32'd1);
        check_val("abort_busy", 32'(o_busy), 32'd0);
        check_val("abort_ready", 32'(o_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_quiet", 32'(o_valid), 32'd0);
        run_word(8'h01, 8'b1000_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
